blake2_hash_arbiter: RTL and testbench

Round-robin controller that shares one BLAKE2 hash core (the 512-bit `blake2b_hash512` instance by default) between `N_REQ` requesters. It accepts one message block at a time from the granted requester and issues it to the core with a single-cycle valid pulse. It then waits for the digest and returns it to the same requester through a valid/ready response channel. It sits between the requester-side logic and the core, which has no backpressure, so the core never has more than one block in flight.

---
 rtl/blake2_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/blake2_hash_arbiter.sv | 138 +++++++++++++
 tb/tb_blake2_hash_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared types and default widths for the BLAKE2 core sharing logic.
package blake2_pkg;

    localparam int BLAKE2B_BLOCK_W = 1024;
    localparam int BLAKE2B_HASH_W  = 512;
    localparam int BLAKE2S_BLOCK_W = 512;
    localparam int BLAKE2S_HASH_W  = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } blake2_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr_i, circularly.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int          pos;
    logic [IW-1:0] pos_idx;

    // Walk from the farthest offset down so the closest requester to ptr_i wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = int'(ptr_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (req_i[pos_idx]) begin
                gnt_o          = '0;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
                any_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blake2_hash_arbiter.sv
// Round-robin sharing of one BLAKE2 core between N_REQ requesters, one block in flight.
// Optional core watchdog enabled with `define BLAKE2_ARB_WATCHDOG_EN.
module blake2_hash_arbiter
    import blake2_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = BLAKE2B_BLOCK_W,
    parameter int HASH_W  = BLAKE2B_HASH_W,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [N_REQ-1:0]        req_v_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_rdy_o,
    output logic                    core_v_o,
    output logic [DATA_W-1:0]       core_data_o,
    input  logic                    core_hash_v_i,
    input  logic [HASH_W-1:0]       core_hash_i,
    output logic [N_REQ-1:0]        rsp_v_o,
    output logic [HASH_W-1:0]       rsp_hash_o,
    output logic                    rsp_err_o,
    input  logic [N_REQ-1:0]        rsp_rdy_i,
    output logic                    busy_o
);

    localparam int            IW       = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("blake2_hash_arbiter: N_REQ must be 2..16 and TIMEOUT >= 1");
    end

    blake2_arb_state_t state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     owner_q;
    logic [DATA_W-1:0] blk_q;
    logic [HASH_W-1:0] hash_q;

    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] blk_d;
    logic [IW-1:0]     ptr_d;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req_i (req_v_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign blk_d = req_data_i[gnt_idx*DATA_W +: DATA_W];
    // The winner drops to lowest priority for the next arbitration round.
    assign ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

`ifdef BLAKE2_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wdt_q;
    logic [CW-1:0] wdt_d;
    logic          err_q;
    assign wdt_d     = wdt_q + 1'b1;
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            blk_q   <= '0;
            hash_q  <= '0;
`ifdef BLAKE2_ARB_WATCHDOG_EN
            err_q   <= 1'b0;
            wdt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        blk_q   <= blk_d;
                        owner_q <= gnt_idx;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef BLAKE2_ARB_WATCHDOG_EN
                    wdt_q   <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real result in the same cycle as the timeout takes precedence.
                    if (core_hash_v_i) begin
                        hash_q  <= core_hash_i;
`ifdef BLAKE2_ARB_WATCHDOG_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= ST_DELIVER;
                    end
`ifdef BLAKE2_ARB_WATCHDOG_EN
                    else if (wdt_d == CW'(TIMEOUT)) begin
                        hash_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DELIVER;
                    end else begin
                        wdt_q   <= wdt_d;
                    end
`endif
                end
                ST_DELIVER: begin
                    if (rsp_rdy_i[owner_q]) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_rdy_o   = (state_q == ST_IDLE) ? gnt : '0;
    assign core_v_o    = (state_q == ST_ISSUE);
    assign core_data_o = blk_q;
    assign rsp_hash_o  = hash_q;
    assign busy_o      = (state_q != ST_IDLE);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_v
        assign rsp_v_o[gi] = (state_q == ST_DELIVER) && (owner_q == IW'(gi));
    end

endmodule

// File: tb/tb_blake2_hash_arbiter.sv
// Scoreboard bench for blake2_hash_arbiter with a latency-programmable core stub.
module tb_blake2_hash_arbiter;

    localparam int N  = 4;
    localparam int DW = 1024;
    localparam int HW = 512;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    req_v_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_rdy_o;
    logic            core_v_o;
    logic [DW-1:0]   core_data_o;
    logic            core_hash_v_i;
    logic [HW-1:0]   core_hash_i;
    logic [N-1:0]    rsp_v_o;
    logic [HW-1:0]   rsp_hash_o;
    logic            rsp_err_o;
    logic [N-1:0]    rsp_rdy_i;
    logic            busy_o;

    always #5 clk = ~clk;

    blake2_hash_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .HASH_W  (HW),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .req_v_i       (req_v_i),
        .req_data_i    (req_data_i),
        .req_rdy_o     (req_rdy_o),
        .core_v_o      (core_v_o),
        .core_data_o   (core_data_o),
        .core_hash_v_i (core_hash_v_i),
        .core_hash_i   (core_hash_i),
        .rsp_v_o       (rsp_v_o),
        .rsp_hash_o    (rsp_hash_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_rdy_i     (rsp_rdy_i),
        .busy_o        (busy_o)
    );

    typedef struct {
        int            owner;
        logic [HW-1:0] hash;
        logic          err;
    } rsp_t;

    int            exp_gnt_q[$];
    logic [DW-1:0] exp_core_q[$];
    rsp_t          exp_rsp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int n_rsp   = 0;
    int accept_cyc = 0;
    int core_cyc   = 0;
    int rsp_rise_cyc = 0;
    logic [HW-1:0] last_hash = '0;

    // Core stub controls
    bit            core_en   = 1'b1;
    int            lat       = 12;
    int            stray_req = 0;
    int            stray_srv = 0;
    logic [HW-1:0] stray_hash = '0;

    function automatic logic [HW-1:0] dig(input logic [DW-1:0] b);
        return b[1023:512] ^ {b[255:0], b[511:256]} ^ {16{32'hA5C3_0F1E}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core stub: pulses the digest lat cycles after core_v_o, or injects a stray pulse.
    initial begin
        int            cd;
        logic [DW-1:0] pend;
        cd = 0;
        pend = '0;
        core_hash_v_i = 1'b0;
        core_hash_i   = '0;
        forever begin
            @(negedge clk);
            core_hash_v_i = 1'b0;
            if (stray_req != stray_srv) begin
                core_hash_v_i = 1'b1;
                core_hash_i   = stray_hash;
                stray_srv     = stray_req;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_hash_v_i = 1'b1;
                    core_hash_i   = dig(pend);
                end
            end
            if (core_v_o && core_en && !nreset) begin
                cd   = lat;
                pend = core_data_o;
            end
        end
    end

    // Monitor: grants, core issues and response handshakes against the scoreboard.
    initial begin
        bit   rsp_prev;
        int   g;
        rsp_t e;
        rsp_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                if ((req_rdy_o & req_v_i) != '0) begin
                    accept_cyc = cyc;
                    n_acc++;
                    if (exp_gnt_q.size() == 0) begin
                        chk("grant_unexpected", req_rdy_o, '0);
                    end else begin
                        g = exp_gnt_q.pop_front();
                        chk("grant", req_rdy_o, DW'(4'b0001 << g));
                        $display("[TB] accept req %0d at cycle %0d", g, cyc);
                    end
                end
                if (core_v_o) begin
                    core_cyc = cyc;
                    if (exp_core_q.size() == 0) begin
                        chk("core_unexpected", core_v_o, '0);
                    end else begin
                        chk("core_data", core_data_o, exp_core_q.pop_front());
                    end
                end
                if ((rsp_v_o != '0) && !rsp_prev) begin
                    rsp_rise_cyc = cyc;
                end
                rsp_prev = (rsp_v_o != '0);
                if ((rsp_v_o & rsp_rdy_i) != '0) begin
                    n_rsp++;
                    last_hash = rsp_hash_o;
                    if (exp_rsp_q.size() == 0) begin
                        chk("rsp_unexpected", rsp_v_o, '0);
                    end else begin
                        e = exp_rsp_q.pop_front();
                        chk("rsp_owner", rsp_v_o, DW'(4'b0001 << e.owner));
                        chk("rsp_hash", rsp_hash_o, e.hash);
                        chk("rsp_err", rsp_err_o, e.err);
                        $display("[TB] response req %0d err %0d at cycle %0d", e.owner, rsp_err_o, cyc);
                    end
                end
            end else begin
                rsp_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input int k, input logic [DW-1:0] blk, input bit with_rsp,
                            input logic [HW-1:0] h, input logic err);
        rsp_t e;
        exp_gnt_q.push_back(k);
        exp_core_q.push_back(blk);
        if (with_rsp) begin
            e.owner = k;
            e.hash  = h;
            e.err   = err;
            exp_rsp_q.push_back(e);
        end
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (n_acc < target && k < 200) begin
            tick();
            k++;
        end
        if (n_acc < target) chk("accept_timeout", DW'(n_acc), DW'(target));
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (n_rsp < target && k < 300) begin
            tick();
            k++;
        end
        if (n_rsp < target) chk("rsp_timeout", DW'(n_rsp), DW'(target));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_req_rdy"}, req_rdy_o, '0);
        chk({tag, "_core_v"}, core_v_o, '0);
        chk({tag, "_core_data"}, core_data_o, '0);
        chk({tag, "_rsp_v"}, rsp_v_o, '0);
        chk({tag, "_rsp_hash"}, rsp_hash_o, '0);
        chk({tag, "_rsp_err"}, rsp_err_o, '0);
        chk({tag, "_busy"}, busy_o, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [DW-1:0] blk [N];
        logic [DW-1:0] b;
        logic [HW-1:0] h;
        int            base;

        nreset     = 1'b1;
        req_v_i    = '0;
        req_data_i = '0;
        rsp_rdy_i  = '0;
        for (int k = 0; k < N; k++) begin
            blk[k] = {32{32'h1000_0000 + 32'(k)}};
        end
        repeat (3) tick();
        check_idle_zero("reset");
        nreset = 1'b0;
        tick();

        // Single requester 1, latency 12
        lat       = 12;
        rsp_rdy_i = 4'b1111;
        b = {128{8'hAB}};
        req_data_i[1*DW +: DW] = b;
        push_txn(1, b, 1'b1, dig(b), 1'b0);
        req_v_i = 4'b0010;
        base = n_acc;
        wait_acc(base + 1);
        req_v_i = '0;
        wait_rsp(1);
        chk("t1_core_latency", DW'(core_cyc), DW'(accept_cyc + 1));
        chk("t1_rsp_latency", DW'(rsp_rise_cyc), DW'(accept_cyc + 14));

        // Reset, then all four requesting: order 0,1,2,3,0,1
        nreset = 1'b1;
        tick();
        nreset = 1'b0;
        lat = 3;
        for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = blk[k];
        for (int i = 0; i < 6; i++) push_txn(i % N, blk[i % N], 1'b1, dig(blk[i % N]), 1'b0);
        req_v_i = 4'b1111;
        base = n_acc;
        wait_acc(base + 6);
        req_v_i = '0;
        wait_rsp(7);

        // Backpressure on owner 2 for 20 cycles; requester 3 waits
        lat = 4;
        rsp_rdy_i = 4'b1011;
        push_txn(2, blk[2], 1'b1, dig(blk[2]), 1'b0);
        push_txn(3, blk[3], 1'b1, dig(blk[3]), 1'b0);
        req_v_i = 4'b1100;
        base = n_acc;
        wait_acc(base + 1);
        req_v_i = 4'b1000;
        for (int k = 0; k < 50 && rsp_v_o == '0; k++) tick();
        for (int i = 0; i < 20; i++) begin
            chk("hold_rsp_v", rsp_v_o, 4'b0100);
            chk("hold_rsp_hash", rsp_hash_o, dig(blk[2]));
            chk("hold_req_rdy", req_rdy_o, '0);
            tick();
        end
        rsp_rdy_i = 4'b1111;
        wait_acc(base + 2);
        req_v_i = '0;
        wait_rsp(9);

        // Stray pulse in IDLE, then a normal transaction from requester 0
        h = last_hash;
        stray_hash = {16{32'hDEAD_BEEF}};
        stray_req++;
        repeat (4) tick();
        chk("stray_busy", busy_o, '0);
        chk("stray_rsp_v", rsp_v_o, '0);
        chk("stray_hash_kept", rsp_hash_o, h);
        lat = 5;
        b = {16{64'h0123_4567_89AB_CDEF}};
        req_data_i[0*DW +: DW] = b;
        push_txn(0, b, 1'b1, dig(b), 1'b0);
        req_v_i = 4'b0001;
        base = n_acc;
        wait_acc(base + 1);
        req_v_i = '0;
        wait_rsp(10);

        // Reset during WAIT; late core result must be dropped
        core_en = 1'b0;
        req_data_i[1*DW +: DW] = blk[1];
        push_txn(1, blk[1], 1'b0, '0, 1'b0);
        req_v_i = 4'b0010;
        base = n_acc;
        wait_acc(base + 1);
        req_v_i = '0;
        repeat (4) tick();
        chk("wait_busy", busy_o, 1'b1);
        nreset = 1'b1;
        repeat (2) tick();
        nreset = 1'b0;
        repeat (3) tick();
        stray_hash = {16{32'hCAFE_F00D}};
        stray_req++;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle_zero("post_reset");
        end

`ifdef BLAKE2_ARB_WATCHDOG_EN
        // Silent core: timeout response 16 cycles after WAIT entry
        req_data_i[0*DW +: DW] = blk[0];
        push_txn(0, blk[0], 1'b1, '0, 1'b1);
        req_v_i = 4'b0001;
        base = n_acc;
        wait_acc(base + 1);
        req_v_i = '0;
        wait_rsp(11);
        chk("wdt_latency", DW'(rsp_rise_cyc), DW'(accept_cyc + 2 + 16));
`endif
        core_en = 1'b1;
        repeat (3) tick();

        chk("sb_gnt_empty", DW'(exp_gnt_q.size()), '0);
        chk("sb_core_empty", DW'(exp_core_q.size()), '0);
        chk("sb_rsp_empty", DW'(exp_rsp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
